bcd_down_counter_n: RTL and testbench

- Parametrised multi-digit BCD down counter with button-driven preset load and a zero-reached pulse.
- Successor to the single-digit 9..0 preset counter in the timer datapath.
- Adds digit count N, a synchronous reset, and a count enable.
- Adds runtime auto-reload or one-shot mode, preset capture for reload, and a one-cycle expiry pulse that drives the display/FSM layer.

---
 rtl/bcd_down_counter_n.sv | 195 +++++++++++++++++++
 tb/tb_bcd_down_counter_n.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_down_counter_n
//
// Multi-digit BCD down counter with a button-driven preset load, count
// enable, runtime one-shot / auto-reload mode and a one-cycle expiry pulse.
//
// Parameters:
//   DIGITS   - number of BCD digits (1..8); Q is 4*DIGITS bits wide.
//   PRESCALE - enabled RUN cycles per count step (used only with the
//              TICK_PRESCALE_EN macro defined).
//
// Optional build macro:
//   TICK_PRESCALE_EN - builds a prescale counter so that a step happens only
//                      every PRESCALE enabled RUN cycles. Undefined: every
//                      enabled RUN cycle is a step.
//
// Ports:
//   clock       in   system clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset (highest priority)
//   preset      in   BCD load value, digit 0 in bits [3:0]
//   botao       in   load strobe, level-sampled every cycle
//   enable      in   count enable
//   auto_reload in   1: reload preset on expiry, 0: stop at zero (one-shot)
//   Q           out  current BCD count
//   zero        out  high while Q == 0
//   done        out  registered one-cycle pulse on expiry
//   running     out  high while in state RUN
// ---------------------------------------------------------------------------
module bcd_down_counter_n #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  botao,
  input  logic                  enable,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  zero,
  output logic                  done,
  output logic                  running
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           done_q, done_d;
  logic           tick_s;

`ifdef TICK_PRESCALE_EN
  // A single-cycle prescale still needs a 1-bit counter to stay legal.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0]  presc_q, presc_d;

  assign tick_s = (presc_q == PMAX);
`else
  // Without the prescaler every enabled RUN cycle is a step; any legal
  // PRESCALE (>= 1) evaluates this to 1.
  assign tick_s = (PRESCALE > 0);
`endif

  // Clamp each BCD digit above 9 down to 9.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Decrement a non-zero BCD value: a digit at 0 wraps to 9 and borrows.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  // Next-state logic: load has priority over counting in every state.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
`ifdef TICK_PRESCALE_EN
    presc_d  = presc_q;
`endif
    if (botao) begin
      count_d  = bcd_clamp(preset);
      reload_d = bcd_clamp(preset);
      state_d  = ST_RUN;
`ifdef TICK_PRESCALE_EN
      presc_d  = {PW{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (enable) begin
`ifdef TICK_PRESCALE_EN
            if (tick_s) begin
              presc_d = {PW{1'b0}};
            end else begin
              presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
            end
`endif
            if (tick_s) begin
              if (count_q != {W{1'b0}}) begin
                count_d = bcd_dec(count_q);
              end else begin
                // Expiry: auto_reload is only looked at here.
                done_d = 1'b1;
                if (auto_reload) begin
                  count_d = reload_q;
                end else begin
                  state_d = ST_DONE;
                end
              end
            end else begin
              count_d = count_q;
            end
          end else begin
            count_d = count_q;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= {W{1'b0}};
      reload_q <= {W{1'b0}};
      done_q   <= 1'b0;
`ifdef TICK_PRESCALE_EN
      presc_q  <= {PW{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
`ifdef TICK_PRESCALE_EN
      presc_q  <= presc_d;
`endif
    end
  end

  assign Q       = count_q;
  assign zero    = (count_q == {W{1'b0}});
  assign done    = done_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_bcd_down_counter_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_down_counter_n
//
// Self-checking bench for bcd_down_counter_n (DIGITS = 2, PRESCALE = 3).
// Directed scenarios followed by random stimulus, every cycle compared
// against a decimal-integer reference model of the counter.
// ---------------------------------------------------------------------------
module tb_bcd_down_counter_n;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
`ifdef TICK_PRESCALE_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] preset = '0;
  logic         botao = 1'b0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] Q;
  logic         zero;
  logic         done;
  logic         running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: value kept as a plain decimal integer.
  int   m_val = 0;
  int   m_rel = 0;
  int   m_st  = 0;   // 0 idle, 1 run, 2 stopped
  int   m_pc  = 0;
  logic m_done = 1'b0;

  bcd_down_counter_n #(.DIGITS(DIGITS), .PRESCALE(3)) dut (
    .clock(clock), .reset(reset), .preset(preset), .botao(botao),
    .enable(enable), .auto_reload(auto_reload),
    .Q(Q), .zero(zero), .done(done), .running(running)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_dec(input logic [W-1:0] p);
    int v, mul, d;
    v = 0; mul = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(p[4*i +: 4]);
      v += ((d > 9) ? 9 : d) * mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic bot, input logic en,
                            input logic ar, input logic [W-1:0] pre);
    m_done = 1'b0;
    if (rst) begin
      m_val = 0; m_rel = 0; m_st = 0; m_pc = 0;
    end else if (bot) begin
      m_val = clamp_dec(pre); m_rel = m_val; m_st = 1; m_pc = 0;
    end else if (m_st == 1 && en) begin
      m_pc++;
      if (m_pc == P) begin
        m_pc = 0;
        if (m_val > 0) m_val--;
        else begin
          m_done = 1'b1;
          if (ar) m_val = m_rel;
          else    m_st  = 2;
        end
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic bot, input logic en,
                       input logic ar, input logic [W-1:0] pre);
    reset = rst; botao = bot; enable = en; auto_reload = ar; preset = pre;
    @(posedge clock);
    model_step(rst, bot, en, ar, pre);
    #1;
    check("Q", 32'(Q), 32'(to_bcd(m_val)));
    check("zero", 32'(zero), 32'(m_val == 0));
    check("done", 32'(done), 32'(m_done));
    check("running", 32'(running), 32'(m_st == 1));
  endtask

  initial begin
    #1;
    // Reset with a simultaneous load: reset wins.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h42);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h42);
    check("rst_Q", 32'(Q), 32'h0);
    check("rst_zero", 32'(zero), 32'h1);

    // Borrow, wrap and auto-reload back to 10.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    check("load_10", 32'(Q), 32'h10);
    for (int i = 0; i < 14 * P; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

    // One-shot expiry, stays at zero, then restart at 05.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
    for (int i = 0; i < 7 * P; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("oneshot_run", 32'(running), 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h05);
    check("restart_05", 32'(Q), 32'h05);

    // Clamp, load-over-step priority, reset-over-load.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hFA);
    check("clamp_99", 32'(Q), 32'h99);
    for (int i = 0; i < P; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h37);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);

    // Enable gating.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h25);
    for (int i = 0; i < P; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("gate_hold", 32'(Q), 32'h24);
    for (int i = 0; i < P; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("gate_23", 32'(Q), 32'h23);

    // All-zero preset with auto-reload: every step expires.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4 * P; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0),
            ($urandom_range(31) == 0),
            ($urandom_range(3) != 0),
            1'($urandom),
            8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
